// File: rtl/axis_sample_router_if.sv
// ---------------------------------------------------------------------------
// axis_sample_router_if
//   Sample bus from the SPI master into the per-axis sample router.
//
//   Signals
//     i_Byte_Count  [CNT_W]   SPI byte counter; tells which axis DataIn is for
//     Load          [1]       one-cycle strobe: DataIn holds a complete sample
//     DataIn        [DATA_W]  two's-complement sample
//
//   Modports
//     master  driven by the SPI master side (or a testbench)
//     slave   consumed by axis_sample_router
// ---------------------------------------------------------------------------
interface axis_sample_router_if #(
  parameter int CNT_W  = 2,
  parameter int DATA_W = 16
);
  logic [CNT_W-1:0]  i_Byte_Count;
  logic              Load;
  logic [DATA_W-1:0] DataIn;

  modport master (
    output i_Byte_Count,
    output Load,
    output DataIn
  );

  modport slave (
    input i_Byte_Count,
    input Load,
    input DataIn
  );
endinterface

// File: rtl/axis_sample_router.sv
// ---------------------------------------------------------------------------
// axis_sample_router
//   Per-axis sample store and display selector between the SPI master and the
//   binary-to-decimal converter. Each completed sample lands in its channel
//   slot (chosen by the SPI byte counter); every channel also keeps an
//   exponential average and a signed peak. One registered output shows a
//   channel picked by sel, or by a timed auto-scan in mode 3.
//
//   Ports
//     clk       in   system clock
//     rst       in   synchronous active-high reset
//     smp       in   sample bus (i_Byte_Count, Load, DataIn), slave modport
//     sel       in   [CNT_W]  displayed channel in modes 0..2
//     mode      in   [2]      0 raw, 1 average, 2 peak, 3 auto-scan raw
//     peak_clr  in   disarms every peak tracker (values retained)
//     DataOut   out  [DATA_W] registered display data
//     o_Ch      out  [CNT_W]  channel currently driving DataOut
//     o_Valid   out  displayed channel has held a sample since reset
// ---------------------------------------------------------------------------
module axis_sample_router #(
  parameter int NUM_CH   = 3,
  parameter int DATA_W   = 16,
  parameter int CNT_W    = 2,
  parameter int AVG_LOG2 = 2,
  parameter int SCAN_DIV = 100000000
) (
  input  logic                 clk,
  input  logic                 rst,
  axis_sample_router_if.slave  smp,
  input  logic [CNT_W-1:0]     sel,
  input  logic [1:0]           mode,
  input  logic                 peak_clr,
  output logic [DATA_W-1:0]    DataOut,
  output logic [CNT_W-1:0]     o_Ch,
  output logic                 o_Valid
);

  localparam int SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  // -------------------------------------------------------------------------
  // Byte counter -> channel. The SPI master finishes the last axis when its
  // counter has already wrapped to 0, hence the rotate by one.
  // -------------------------------------------------------------------------
  logic             load_ok;
  logic [CNT_W-1:0] tgt_ch;

  always_comb begin
    load_ok = 1'b0;
    tgt_ch  = '0;
    if (smp.Load) begin
      if (smp.i_Byte_Count == '0) begin
        load_ok = 1'b1;
        tgt_ch  = CNT_W'(NUM_CH - 1);
      end else if (32'(smp.i_Byte_Count) <= NUM_CH - 1) begin
        load_ok = 1'b1;
        tgt_ch  = smp.i_Byte_Count - CNT_W'(1);
      end
    end
  end

  // Gathered per-channel state for the output mux.
  logic [DATA_W-1:0] raw_arr  [NUM_CH];
  logic [DATA_W-1:0] avg_arr  [NUM_CH];
  logic [DATA_W-1:0] peak_arr [NUM_CH];
  logic [NUM_CH-1:0] seen_vec;

  // -------------------------------------------------------------------------
  // Per-channel raw / average / peak trackers
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic                     hit;
      logic                     armed_eff;
      logic signed [DATA_W:0]   diff;
      logic signed [DATA_W:0]   step;
      logic [DATA_W-1:0]        avg_upd;

      logic [DATA_W-1:0] raw_q,  raw_d;
      logic [DATA_W-1:0] avg_q,  avg_d;
      logic [DATA_W-1:0] peak_q, peak_d;
      logic              seen_q, seen_d;
      logic              armed_q, armed_d;

      assign hit = load_ok && (tgt_ch == CNT_W'(gi));

      // Difference taken one bit wider so it cannot overflow before the
      // arithmetic shift; the sum is then truncated back to DATA_W.
      assign diff    = $signed({smp.DataIn[DATA_W-1], smp.DataIn})
                     - $signed({avg_q[DATA_W-1], avg_q});
      assign step    = diff >>> AVG_LOG2;
      assign avg_upd = avg_q + step[DATA_W-1:0];

      // A peak_clr in the same cycle as a Load makes that Load re-arm.
      assign armed_eff = armed_q && !peak_clr;

      always_comb begin
        raw_d   = raw_q;
        avg_d   = avg_q;
        peak_d  = peak_q;
        seen_d  = seen_q;
        armed_d = armed_eff;
        if (hit) begin
          raw_d  = smp.DataIn;
          avg_d  = seen_q ? avg_upd : smp.DataIn;
          seen_d = 1'b1;
          if (!armed_eff || ($signed(smp.DataIn) > $signed(peak_q))) begin
            peak_d  = smp.DataIn;
            armed_d = 1'b1;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          raw_q   <= '0;
          avg_q   <= '0;
          peak_q  <= '0;
          seen_q  <= 1'b0;
          armed_q <= 1'b0;
        end else begin
          raw_q   <= raw_d;
          avg_q   <= avg_d;
          peak_q  <= peak_d;
          seen_q  <= seen_d;
          armed_q <= armed_d;
        end
      end

      assign raw_arr[gi]  = raw_q;
      assign avg_arr[gi]  = avg_q;
      assign peak_arr[gi] = peak_q;
      assign seen_vec[gi] = seen_q;
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Auto-scan: dwell SCAN_DIV cycles per channel; parked at 0 outside mode 3
  // so re-entering always starts from channel 0.
  // -------------------------------------------------------------------------
  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [CNT_W-1:0]  scan_ch_q,  scan_ch_d;

  always_comb begin
    scan_cnt_d = '0;
    scan_ch_d  = '0;
    if (mode == 2'd3) begin
      if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
        scan_cnt_d = '0;
        scan_ch_d  = (scan_ch_q == CNT_W'(NUM_CH - 1)) ? '0
                                                       : scan_ch_q + CNT_W'(1);
      end else begin
        scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        scan_ch_d  = scan_ch_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q <= '0;
      scan_ch_q  <= '0;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      scan_ch_q  <= scan_ch_d;
    end
  end

  // -------------------------------------------------------------------------
  // Output register
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0]  disp_ch;
  logic [DATA_W-1:0] dout_q,  dout_d;
  logic [CNT_W-1:0]  och_q,   och_d;
  logic              valid_q, valid_d;

  assign disp_ch = (mode == 2'd3) ? scan_ch_q : sel;

  always_comb begin
    dout_d  = '0;
    valid_d = 1'b0;
    och_d   = disp_ch;
    if ((32'(disp_ch) < NUM_CH) && seen_vec[disp_ch]) begin
      valid_d = 1'b1;
      case (mode)
        2'd1:    dout_d = avg_arr[disp_ch];
        2'd2:    dout_d = peak_arr[disp_ch];
        default: dout_d = raw_arr[disp_ch];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q  <= '0;
      och_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      och_q   <= och_d;
      valid_q <= valid_d;
    end
  end

  assign DataOut = dout_q;
  assign o_Ch    = och_q;
  assign o_Valid = valid_q;

endmodule

// File: tb/tb_axis_sample_router.sv
// ---------------------------------------------------------------------------
// tb_axis_sample_router
//   Directed bench for axis_sample_router (NUM_CH=3, DATA_W=16, AVG_LOG2=2,
//   SCAN_DIV=4). Inputs change 1 ns after a rising edge; outputs are read at
//   the same point, i.e. after the edge has settled.
// ---------------------------------------------------------------------------
module tb_axis_sample_router;
  localparam int NUM_CH = 3;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [CNT_W-1:0]  sel = '0;
  logic [1:0]        mode = 2'd0;
  logic              peak_clr = 1'b0;
  logic [DATA_W-1:0] DataOut;
  logic [CNT_W-1:0]  o_Ch;
  logic              o_Valid;

  int n_cmp = 0;
  int n_bad = 0;

  axis_sample_router_if #(.CNT_W(CNT_W), .DATA_W(DATA_W)) smp_if ();

  axis_sample_router #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNT_W(CNT_W),
    .AVG_LOG2(2), .SCAN_DIV(4)
  ) dut (
    .clk(clk), .rst(rst), .smp(smp_if.slave),
    .sel(sel), .mode(mode), .peak_clr(peak_clr),
    .DataOut(DataOut), .o_Ch(o_Ch), .o_Valid(o_Valid)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one sample for exactly one edge.
  task automatic do_load(input logic [CNT_W-1:0] cnt, input logic [DATA_W-1:0] d);
    smp_if.i_Byte_Count = cnt;
    smp_if.DataIn       = d;
    smp_if.Load         = 1'b1;
    tick();
    smp_if.Load         = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [DATA_W-1:0] d,
                           input logic v, input logic [CNT_W-1:0] ch);
    check_val({tag, ".data"},  32'(DataOut), 32'(d));
    check_val({tag, ".valid"}, 32'(o_Valid), 32'(v));
    check_val({tag, ".ch"},    32'(o_Ch),    32'(ch));
  endtask

  initial begin
    smp_if.i_Byte_Count = '0;
    smp_if.DataIn       = '0;
    smp_if.Load         = 1'b0;

    // ---- reset state ----
    do_reset();
    check_out("reset", 16'h0000, 1'b0, 2'd0);

    // ---- nothing seen yet ----
    sel = 2'd1;
    tick();
    check_out("empty_sel1", 16'h0000, 1'b0, 2'd1);

    // ---- raw capture and byte-count mapping ----
    sel = 2'd0;
    do_load(2'd1, 16'h0100);
    check_val("lat_x.valid", 32'(o_Valid), 32'd0);
    tick();
    check_out("raw_x", 16'h0100, 1'b1, 2'd0);
    sel = 2'd1;
    do_load(2'd2, 16'hFF00);
    tick();
    check_out("raw_y", 16'hFF00, 1'b1, 2'd1);
    sel = 2'd2;
    do_load(2'd0, 16'h0040);
    tick();
    check_out("raw_z", 16'h0040, 1'b1, 2'd2);

    // ---- out-of-range select and ignored Load ----
    sel = 2'd3;
    tick();
    check_out("sel3", 16'h0000, 1'b0, 2'd3);
    do_load(2'd3, 16'h1234);
    tick();
    sel = 2'd0; tick(); check_out("keep_x", 16'h0100, 1'b1, 2'd0);
    sel = 2'd1; tick(); check_out("keep_y", 16'hFF00, 1'b1, 2'd1);
    sel = 2'd2; tick(); check_out("keep_z", 16'h0040, 1'b1, 2'd2);
    mode = 2'd1; sel = 2'd0; tick(); check_val("keep_avg_x",  32'(DataOut), 32'h0100);
    mode = 2'd2;             tick(); check_val("keep_peak_x", 32'(DataOut), 32'h0100);

    // ---- exponential average, k = 2 ----
    do_reset();
    mode = 2'd1; sel = 2'd0;
    do_load(2'd1, 16'd0);   tick(); check_val("avg0",   32'(DataOut), 32'd0);
    do_load(2'd1, 16'd100); tick(); check_val("avg25",  32'(DataOut), 32'd25);
    do_load(2'd1, 16'd100); tick(); check_val("avg43",  32'(DataOut), 32'd43);
    do_load(2'd1, 16'hFF9C); tick(); check_val("avg7",  32'(DataOut), 32'd7);
    mode = 2'd0; tick(); check_val("raw_m100", 32'(DataOut), 32'hFF9C);

    // ---- signed peak ----
    mode = 2'd2; sel = 2'd2;
    do_load(2'd0, 16'd5);    tick(); check_val("pk5",    32'(DataOut), 32'd5);
    do_load(2'd0, 16'hFFFD); tick(); check_val("pk5b",   32'(DataOut), 32'd5);
    do_load(2'd0, 16'd20);   tick(); check_val("pk20",   32'(DataOut), 32'd20);
    do_load(2'd0, 16'd7);    tick(); check_val("pk20b",  32'(DataOut), 32'd20);
    peak_clr = 1'b1; tick(); peak_clr = 1'b0;
    tick(); check_val("pk_retained", 32'(DataOut), 32'd20);
    do_load(2'd0, 16'hFFF8); tick(); check_val("pk_m8", 32'(DataOut), 32'hFFF8);
    peak_clr = 1'b1;
    do_load(2'd0, 16'd4);
    peak_clr = 1'b0;
    tick(); check_val("pk_clr_load4", 32'(DataOut), 32'd4);
    do_load(2'd0, 16'd2);    tick(); check_val("pk_rearmed", 32'(DataOut), 32'd4);

    // ---- auto-scan (raw values: X=0xFF9C, Y=0x0222, Z=0x0002) ----
    do_load(2'd2, 16'h0222);
    mode = 2'd3;
    for (int i = 0; i < 18; i++) begin
      int c;
      logic [DATA_W-1:0] ev;
      c  = (i / 4) % 3;
      ev = (c == 0) ? 16'hFF9C : ((c == 1) ? 16'h0222 : 16'h0002);
      tick();
      check_val($sformatf("scan%0d.ch", i),   32'(o_Ch),    32'(c));
      check_val($sformatf("scan%0d.data", i), 32'(DataOut), 32'(ev));
    end
    // Leave mid-dwell on channel 1, then come back: scan restarts at 0.
    mode = 2'd0; sel = 2'd2;
    tick(); check_val("scan_exit.ch", 32'(o_Ch), 32'd2);
    mode = 2'd3;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val($sformatf("rescan%0d.ch", i), 32'(o_Ch), (i < 4) ? 32'd0 : 32'd1);
    end

    // ---- reset mid-scan coincident with a Load ----
    rst = 1'b1;
    do_load(2'd1, 16'h7777);
    rst = 1'b0;
    check_out("rst_scan", 16'h0000, 1'b0, 2'd0);
    tick(); check_out("rst_scan2", 16'h0000, 1'b0, 2'd0);
    mode = 2'd0; sel = 2'd0;
    tick(); check_out("rst_discard", 16'h0000, 1'b0, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/axis_sample_router.md
Name: axis_sample_router

Overview:
- Parametrised per-axis sample store and display selector for the SPI accelerometer path, sitting between the SPI master and the binary-to-decimal converter.
- Captures each completed sample into its channel slot using the SPI byte counter, and keeps a per-channel exponential average and signed peak.
- Drives one registered output selected either by a channel select input or by a timed auto-scan across all channels.

Parameters:
NUM_CH, 3, number of axis channels (2..8)
DATA_W, 16, sample width, two's complement
CNT_W, 2, width of i_Byte_Count and sel; 2^CNT_W >= NUM_CH
AVG_LOG2, 2, exponential average shift k (0..4)
SCAN_DIV, 100000000, auto-scan dwell in clk cycles per channel (>= 2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
i_Byte_Count  in  CNT_W  SPI master byte counter; identifies which channel DataIn belongs to
Load  in  1  one-cycle strobe: DataIn is a complete sample
DataIn  in  DATA_W  sample from SPI master
sel  in  CNT_W  displayed channel in modes 0..2
mode  in  2  0 raw, 1 average, 2 peak, 3 auto-scan raw
peak_clr  in  1  clears all peak trackers
DataOut  out  DATA_W  registered display data to binary-to-decimal converter
o_Ch  out  CNT_W  channel currently driving DataOut
o_Valid  out  1  displayed channel has held at least one sample since reset

Behaviour:
- Interface: one clock, clk; reset rst is synchronous, active-high. All state updates on the rising edge of clk.
- Reset: all raw, average and peak registers are 0. All seen flags are 0, and peak-armed flags are 0. Scan counter and scan channel are 0. DataOut, o_Ch and o_Valid are 0. Reset wins over every other input in the same cycle and aborts any scan in progress.
- Channel mapping on Load:
  - i_Byte_Count = 0 targets channel NUM_CH-1.
  - i_Byte_Count = c, with 1 <= c <= NUM_CH-1, targets channel c-1.
  - Any other value: the Load is ignored and no state changes.
  - For NUM_CH = 3: 1 -> X (ch0), 2 -> Y (ch1), 0 -> Z (ch2).
- On an accepted Load to channel c, all of the following take effect at the same edge:
  - raw[c] <= DataIn.
  - If seen[c] = 0: avg[c] <= DataIn. Otherwise avg[c] <= avg[c] + ((DataIn - avg[c]) >>> AVG_LOG2). The difference is computed signed at DATA_W+1 bits with an arithmetic shift, and the result is truncated to DATA_W.
  - If armed[c] = 0 or DataIn >(signed) peak[c]: peak[c] <= DataIn, and armed[c] <= 1.
  - seen[c] <= 1.
- peak_clr: sets armed = 0 for all channels; peak values are left unchanged. If peak_clr and Load occur in the same cycle, the Load uses armed = 0, so peak[c] takes DataIn and that channel ends armed.
- Auto-scan:
  - While mode != 3, the scan counter and scan channel are held at 0.
  - In mode 3 the counter increments each cycle. On reaching SCAN_DIV-1 it returns to 0 and the scan channel advances, wrapping NUM_CH-1 -> 0.
- Display channel d: the scan channel in mode 3, otherwise sel.
- Output register, updated every cycle:
  - o_Ch <= d.
  - If d >= NUM_CH or seen[d] = 0: DataOut <= 0 and o_Valid <= 0.
  - Otherwise o_Valid <= 1, and DataOut <= raw[d] for modes 0 and 3, avg[d] for mode 1, peak[d] for mode 2.
  - In mode 2 with armed[d] = 0, DataOut shows the retained peak[d].
- Latency:
  - Load sampled at edge n: the stored value is visible on DataOut after edge n+1.
  - sel or mode change sampled at edge n: reflected on DataOut after edge n.
- No handshake back-pressure; every accepted Load is absorbed in one cycle.

Test Plan:
1. Reset, then Load with i_Byte_Count = 1, 2, 0 and DataIn = 0x0100, 0xFF00, 0x0040; mode 0, sel = 0/1/2 -> DataOut = 0x0100 / 0xFF00 / 0x0040, o_Valid = 1, each 2 cycles after its Load.
2. Straight after reset, with mode 0 and sel = 1 -> DataOut = 0, o_Valid = 0. With sel = 3 (out of range) after data is loaded -> DataOut = 0, o_Valid = 0. A Load with i_Byte_Count = 3 leaves all registers unchanged.
3. AVG_LOG2 = 2, mode 1, sel = 0. Load ch0 with 0, then 100, then 100 -> DataOut = 0, 25, 43. Then Load -100 -> DataOut = 7.
4. Mode 2, sel = 2. Z samples 5, -3, 20, 7 -> DataOut ends at 20. Pulse peak_clr (retained value still shown as 20), then Z = -8 -> 0xFFF8. peak_clr coincident with Load Z = 4 -> 4.
5. SCAN_DIV = 4, mode 3, all channels loaded -> o_Ch runs 0,0,0,0,1,1,1,1,2,2,2,2,0. Leaving mode 3 mid-dwell and re-entering restarts the scan at channel 0.
6. Assert rst mid-scan in the same cycle as a Load -> all outputs 0 on the next edge, the Load is discarded, and seen is cleared (o_Valid = 0).
